// File: rtl/eth_log_collector_pkg.sv
// Shared types for the log collector: FSM states and the stored-entry layout.
// The data width is fixed at 64 here. The top refuses to elaborate if its stream width differs.
package eth_log_collector_pkg;

  localparam int LOG_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [LOG_DATA_W-1:0] data;
  } log_entry_t;

endpackage

// File: rtl/eth_log_collector_mem.sv
// Simple dual-port RAM with one write port and one registered read port.
// Read data appears the cycle after rd_en. The contents are never reset.
module eth_log_collector_mem #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_log_collector.sv
// Stores whole log messages, drops any message that will not fit, and never backpressures.
// The host pops one word per cycle with one cycle of latency. The counters are present only when ETH_LOG_COLLECTOR_STATS_EN is defined.
module eth_log_collector
  import eth_log_collector_pkg::*;
#(
  parameter int C_AXI_WIDTH      = 32,
  parameter int C_AXIS_LOG_WIDTH = 64,
  parameter int C_BUFFER_SIZE    = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               srst,
  input  logic [C_AXIS_LOG_WIDTH-1:0]        s_axis_log_tdata,
  input  logic                               s_axis_log_tlast,
  input  logic                               s_axis_log_tvalid,
  output logic                               s_axis_log_tready,
  input  logic                               rd_req,
  output logic [C_AXI_WIDTH-1:0]             rd_data,
  output logic                               rd_valid,
  output logic                               rd_last,
  output logic                               rd_empty,
  output logic [$clog2(2*C_BUFFER_SIZE):0]   rd_level,
  output logic [63:0]                        drop_count,
  output logic [63:0]                        msg_count
);

  localparam int AW = $clog2(C_BUFFER_SIZE);
  localparam int PW = AW + 1;

  if (C_AXIS_LOG_WIDTH != 2 * C_AXI_WIDTH) begin : g_bad_width
    $error("eth_log_collector: C_AXIS_LOG_WIDTH must equal 2*C_AXI_WIDTH");
  end
  if (C_AXIS_LOG_WIDTH != LOG_DATA_W) begin : g_bad_entry
    $error("eth_log_collector: C_AXIS_LOG_WIDTH must match the stored entry width");
  end
  if (C_BUFFER_SIZE < 4 || (C_BUFFER_SIZE & (C_BUFFER_SIZE - 1)) != 0) begin : g_bad_depth
    $error("eth_log_collector: C_BUFFER_SIZE must be a power of two >= 4");
  end

  state_t        state_q, state_d;
  logic [PW-1:0] wp_q, wp_d, cp_q, cp_d, rp_q, rp_d;
  logic          half_q, half_d, rd_upper_q, rd_upper_d;
  logic          rd_valid_q, rd_valid_d, tready_q, tready_d;
  logic          rst, accept, full, pop, wr_en;
  log_entry_t    wr_entry, rd_entry;

  assign rst      = !rst_n || srst;
  assign accept   = s_axis_log_tvalid && tready_q;
  // The writer counts uncommitted entries too, so a partial message can fill the buffer.
  assign full     = (wp_q - rp_q) == PW'(C_BUFFER_SIZE);
  assign rd_empty = (rp_q == cp_q);
  assign pop      = rd_req && !rd_empty;
  assign wr_entry = '{last: s_axis_log_tlast, data: s_axis_log_tdata};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        ST_IDLE, ST_WRITE: begin
          if (s_axis_log_tlast) state_d = ST_IDLE;
          else if (full)        state_d = ST_DROP;
          else                  state_d = ST_WRITE;
        end
        ST_DROP: if (s_axis_log_tlast) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en      = 1'b0;
    wp_d       = wp_q;
    cp_d       = cp_q;
    rp_d       = rp_q;
    half_d     = half_q;
    rd_upper_d = rd_upper_q;
    rd_valid_d = pop;
    tready_d   = 1'b1;
    if (accept && state_q != ST_DROP) begin
      if (full) begin
        wp_d = cp_q;
      end else begin
        wr_en = 1'b1;
        wp_d  = wp_q + PW'(1);
        if (s_axis_log_tlast) cp_d = wp_q + PW'(1);
      end
    end
    if (pop) begin
      rd_upper_d = half_q;
      half_d     = !half_q;
      if (half_q) rp_d = rp_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      cp_q       <= '0;
      rp_q       <= '0;
      half_q     <= 1'b0;
      rd_upper_q <= 1'b0;
      rd_valid_q <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      cp_q       <= cp_d;
      rp_q       <= rp_d;
      half_q     <= half_d;
      rd_upper_q <= rd_upper_d;
      rd_valid_q <= rd_valid_d;
      tready_q   <= tready_d;
    end
  end

  eth_log_collector_mem #(
    .DEPTH (C_BUFFER_SIZE),
    .WIDTH ($bits(log_entry_t))
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wp_q[AW-1:0]),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_addr (rp_q[AW-1:0]),
    .rd_data (rd_entry)
  );

  assign s_axis_log_tready = tready_q;
  assign rd_valid = rd_valid_q;
  // The RAM output register is not reset, so the outputs are gated until a word is actually popped.
  assign rd_data  = !rd_valid_q ? '0 :
                    rd_upper_q  ? rd_entry.data[C_AXIS_LOG_WIDTH-1:C_AXI_WIDTH] :
                                  rd_entry.data[C_AXI_WIDTH-1:0];
  assign rd_last  = rd_valid_q && rd_upper_q && rd_entry.last;
  assign rd_level = {(cp_q - rp_q), 1'b0} - {{PW{1'b0}}, half_q};

`ifdef ETH_LOG_COLLECTOR_STATS_EN
  logic [63:0] drop_count_q, drop_count_d, msg_count_q, msg_count_d;

  always_comb begin
    drop_count_d = drop_count_q + 64'(accept && state_q != ST_DROP && full);
    msg_count_d  = msg_count_q + 64'(wr_en && s_axis_log_tlast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
      msg_count_q  <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      msg_count_q  <= msg_count_d;
    end
  end

  assign drop_count = drop_count_q;
  assign msg_count  = msg_count_q;
`else
  assign drop_count = '0;
  assign msg_count  = '0;
`endif

endmodule

// File: doc/eth_log_collector.md
ETH_LOG_COLLECTOR -- requirements
Module: eth_log_collector

Interface
REQ-001 SHALL have parameter C_AXI_WIDTH, 32, host read word width.
REQ-002 SHALL have parameter C_AXIS_LOG_WIDTH, 64, log stream width; SHALL equal 2*C_AXI_WIDTH (elaboration error otherwise).
REQ-003 SHALL have parameter C_BUFFER_SIZE, 1024, entries of C_AXIS_LOG_WIDTH bits; power of two, >=4.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 srst  in  1  soft reset, synchronous, active-high, same effect as rst_n.
REQ-007 s_axis_log_tdata  in  C_AXIS_LOG_WIDTH  log entry from eth_frame_loop log master.
REQ-008 s_axis_log_tlast  in  1  last entry of a log message.
REQ-009 s_axis_log_tvalid  in  1  entry valid.
REQ-010 s_axis_log_tready  out  1  entry accepted when tvalid&tready.
REQ-011 rd_req  in  1  host pop request, one 32-bit word per cycle.
REQ-012 rd_data  out  C_AXI_WIDTH  popped word.
REQ-013 rd_valid  out  1  rd_data/rd_last valid this cycle.
REQ-014 rd_last  out  1  rd_data is upper half of a message's last entry.
REQ-015 rd_empty  out  1  no committed words available.
REQ-016 rd_level  out  $clog2(2*C_BUFFER_SIZE)+1  committed unread 32-bit words.
REQ-017 drop_count  out  64  messages discarded for lack of space.
REQ-018 msg_count  out  64  messages committed.

Function
REQ-019 tready SHALL be 1 in every non-reset cycle; the block never backpressures, it drops.
REQ-020 FSM states SHALL be IDLE, WRITE, DROP; IDLE->WRITE on accepted non-last entry with space; IDLE/WRITE->DROP on accepted entry with buffer full; DROP->IDLE on accepted tlast; WRITE->IDLE on accepted tlast.
REQ-021 Accepted entries SHALL be stored with their tlast bit at write pointer wp; wp advances per stored entry.
REQ-022 Commit pointer cp SHALL be set to wp+1 on the cycle a tlast entry is stored; msg_count SHALL increment same cycle.
REQ-023 Entering DROP SHALL rewind wp to cp and increment drop_count once; entries in DROP SHALL be discarded.
REQ-024 Full SHALL be wp - rp == C_BUFFER_SIZE, using (log2(C_BUFFER_SIZE)+1)-bit pointers wrapping modulo 2*C_BUFFER_SIZE; empty (reader) SHALL be rp == cp.
REQ-025 A message longer than C_BUFFER_SIZE entries SHALL always be dropped.
REQ-026 Each entry SHALL be read as two words, bits [C_AXI_WIDTH-1:0] first; rp advances after the upper word.
REQ-027 rd_req with rd_empty=0 SHALL produce rd_valid=1 exactly one cycle later; rd_req with rd_empty=1 SHALL be ignored.
REQ-028 rd_last SHALL be 1 only with rd_valid on the upper word of an entry stored with tlast.
REQ-029 rd_level SHALL be 2*(cp-rp) minus 1 if the lower half of entry rp was already read.
REQ-030 Simultaneous commit and read SHALL both take effect; rd_empty/rd_level reflect both next cycle.
REQ-031 Freed space SHALL be visible to the writer the cycle after rp advances.
REQ-032 Counters SHALL wrap modulo 2^64.

Reset
REQ-033 On rst_n=0 or srst=1: state IDLE, wp=cp=rp=0, half-select=0, tready=0, rd_valid=0, rd_last=0, rd_data=0, rd_empty=1, rd_level=0, drop_count=0, msg_count=0.
REQ-034 Reset mid-message SHALL discard all buffered and partial data; the remainder of an in-flight message after reset SHALL be stored as a new message.
REQ-035 Memory contents need not be cleared.

Configuration
REQ-036 Macro ETH_LOG_COLLECTOR_STATS_EN defined: drop_count and msg_count implemented per REQ-022/023/032.
REQ-037 Macro undefined: drop_count and msg_count SHALL be constant 0; drop/commit behaviour unchanged.

Structure
REQ-038 Package eth_log_collector_pkg SHALL hold the FSM state enum and the stored-entry struct (data + last bit).
REQ-039 Storage SHALL be sub-module eth_log_collector_mem: simple dual-port RAM, one write port, one registered read port, depth C_BUFFER_SIZE, width C_AXIS_LOG_WIDTH+1.

Verification
REQ-040 3-entry message 0x1111_0000_0000_000A..C, tlast on 3rd -> msg_count=1, rd_level=6; 6 pops return 0x0000000A,0x11110000,...; rd_last only on 6th.
REQ-041 C_BUFFER_SIZE=4, fill with 4-entry message, send 2-entry message -> drop_count=1, msg_count=1, rd_level=8.
REQ-042 C_BUFFER_SIZE=4, 5-entry message into empty buffer -> dropped, rd_empty=1, drop_count=1; next 1-entry message commits.
REQ-043 Pop continuously while streaming 1-entry messages over 3 full pointer wraps -> every word in order, no drops.
REQ-044 srst asserted after 2 entries of a 4-entry message -> rd_empty=1, counters 0; remaining 2 entries commit as one message, rd_level=4.
REQ-045 rd_req while rd_empty=1 -> rd_valid stays 0, rp unchanged.
